// File: rtl/mdu_pkg.sv
// Shared type definitions for the execute-stage units (package common).
// Holds the ALU and MDU operation encodings, the MDU FSM state enum, and
// small helpers that classify MDU operations.
package common;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_operation_type;

  // Encodings 8..15 are undefined and complete as illegal.
  typedef enum logic [3:0] {
    MUL    = 4'd0,
    MULH   = 4'd1,
    MULHSU = 4'd2,
    MULHU  = 4'd3,
    DIV    = 4'd4,
    DIVU   = 4'd5,
    REM    = 4'd6,
    REMU   = 4'd7
  } mdu_operation_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  function automatic logic is_mul_op(input mdu_operation_type op);
    return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == MULHU);
  endfunction

  function automatic logic is_div_op(input mdu_operation_type op);
    return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
  endfunction

  function automatic logic is_rem_op(input mdu_operation_type op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/mdu_div.sv
// Restoring divider core: one quotient bit per cycle on operand magnitudes,
// with sign fix-up applied combinationally on the outputs. done is high for
// the single cycle after the last bit step; the caller samples results then.
// Divide-by-zero and signed overflow are filtered out by the caller.
module mdu_div_core
  import common::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  is_signed,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  done
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W);

  logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, negq_q, negq_d, negr_q, negr_d;
  logic [W:0]    rem_sh, diff;

  // Shift in the next dividend bit and trial-subtract the divisor.
  assign rem_sh = {rem_q, quo_q[W-1]};
  assign diff   = rem_sh - {1'b0, div_q};

  // Next-state: load magnitudes on start, else one restoring step per cycle.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    negq_d = negq_q;
    negr_d = negr_q;
    if (start) begin
      rem_d  = '0;
      quo_d  = (is_signed && a[W-1]) ? -a : a;
      div_d  = (is_signed && b[W-1]) ? -b : b;
      cnt_d  = '0;
      busy_d = 1'b1;
      negq_d = is_signed && (a[W-1] ^ b[W-1]);
      negr_d = is_signed && a[W-1];
    end else if (busy_q) begin
      if (cnt_q != CNT_LAST) begin
        if (!diff[W]) begin
          rem_d = diff[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[W-1:0];
          quo_d = {quo_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end

  assign done      = busy_q && (cnt_q == CNT_LAST);
  assign quotient  = negq_q ? -quo_q : quo_q;
  assign remainder = negr_q ? -rem_q : rem_q;

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit (RISC-V M semantics, DATA_WIDTH generic).
// Multiply: shift-add on magnitudes for DATA_WIDTH cycles, then one cycle to
// negate and select the product half. Divide lives in mdu_div_core and is
// built only when MDU_DIV_EN is defined; otherwise divide ops complete at
// once as illegal. Zero divisor, signed overflow and undefined encodings
// skip CALC and complete one cycle after accept.
module mdu
  import common::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  mdu_operation_type     operation,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  illegal_op
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W);
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

  mdu_state_t        state_q, state_d;
  mdu_operation_type op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*W-1:0]    acc_q, acc_d, mcand_q, mcand_d, prod;
  logic [W-1:0]      mplier_q, mplier_d, result_q, result_d;
  logic              neg_q, neg_d, illegal_q, illegal_d;
  logic              a_neg, b_neg;

`ifdef MDU_DIV_EN
  logic         div_start, div_signed, div_done;
  logic [W-1:0] div_quo, div_rem;

  assign div_signed = (operation == DIV) || (operation == REM);

  mdu_div_core #(.DATA_WIDTH(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .a         (A),
    .b         (B),
    .is_signed (div_signed),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );
`endif

  // Operand sign handling for the high-half multiplies.
  assign a_neg = ((operation == MULH) || (operation == MULHSU)) && A[W-1];
  assign b_neg = (operation == MULH) && B[W-1];
  assign prod  = neg_q ? -acc_q : acc_q;

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    result_d  = result_q;
    illegal_d = illegal_q;
`ifdef MDU_DIV_EN
    div_start = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d      = operation;
          cnt_d     = '0;
          illegal_d = 1'b0;
          if (is_mul_op(operation)) begin
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, (a_neg ? -A : A)};
            mplier_d = b_neg ? -B : B;
            neg_d    = a_neg ^ b_neg;
            state_d  = CALC;
          end else if (is_div_op(operation)) begin
`ifdef MDU_DIV_EN
            if (B == '0) begin
              result_d = is_rem_op(operation) ? A : '1;
              state_d  = DONE;
            end else if (div_signed && (A == MOST_NEG) && (B == '1)) begin
              result_d = (operation == DIV) ? A : '0;
              state_d  = DONE;
            end else begin
              div_start = 1'b1;
              state_d   = CALC;
            end
`else
            result_d  = '0;
            illegal_d = 1'b1;
            state_d   = DONE;
`endif
          end else begin
            result_d  = '0;
            illegal_d = 1'b1;
            state_d   = DONE;
          end
        end
      end
      CALC: begin
        if (is_mul_op(op_q)) begin
          if (cnt_q != CNT_LAST) begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
          end else begin
            result_d = (op_q == MUL) ? prod[W-1:0] : prod[2*W-1:W];
            state_d  = DONE;
          end
        end
`ifdef MDU_DIV_EN
        else if (div_done) begin
          result_d = is_rem_op(op_q) ? div_rem : div_quo;
          state_d  = DONE;
        end
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; reset abandons any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= MUL;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      neg_q     <= neg_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign result     = result_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu (DATA_WIDTH 32). Expected values come from a
// behavioural model using 64-bit arithmetic; expectations follow MDU_DIV_EN.
module tb_mdu;
  import common::*;
  localparam int W = 32;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, illegal_op;
  mdu_operation_type operation = MUL;
  logic [W-1:0] A = '0, B = '0, result;

  int n_tests = 0, n_fail = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] res;
    logic         ill;
    int           lat;
  } exp_t;
  exp_t sb[$];

  mdu #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .A(A), .B(B), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input string tag, input logic [3:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [63:0] p;
    logic signed [63:0] sp;
    int sa, sd;
    e.tag = tag; e.res = '0; e.ill = 1'b0; e.lat = 33;
    sa = a; sd = b;
    case (op)
      4'd0: begin p = {32'b0, a} * {32'b0, b}; e.res = p[31:0]; end
      4'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); e.res = sp[63:32]; end
      4'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); e.res = sp[63:32]; end
      4'd3: begin p = {32'b0, a} * {32'b0, b}; e.res = p[63:32]; end
      4'd4, 4'd5, 4'd6, 4'd7: begin
`ifdef MDU_DIV_EN
        if (b == 0) begin
          e.lat = 1;
          e.res = (op == 4'd4 || op == 4'd5) ? 32'hFFFF_FFFF : a;
        end else if ((op == 4'd4 || op == 4'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lat = 1;
          e.res = (op == 4'd4) ? a : 32'h0;
        end else begin
          case (op)
            4'd4:    e.res = sa / sd;
            4'd5:    e.res = a / b;
            4'd6:    e.res = sa % sd;
            default: e.res = a % b;
          endcase
        end
`else
        e.lat = 1; e.ill = 1'b1;
`endif
      end
      default: begin e.lat = 1; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    exp_t e;
    int cyc;
    logic got;
    sb.push_back(model(tag, op, a, b));
    @(negedge clk);
    chk({tag, ":in_ready"}, in_ready, 1);
    in_valid = 1'b1; operation = mdu_operation_type'(op); A = a; B = b;
    @(posedge clk); #1;
    in_valid = 1'b0; A = ~a; B = ~b; operation = mdu_operation_type'(4'd3);
    cyc = 0; got = 1'b0;
    while (cyc < 100 && !got) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    e = sb.pop_front();
    chk({tag, ":timeout"}, got, 1);
    if (got) begin
      chk({tag, ":latency"}, cyc, e.lat);
      chk({tag, ":illegal"}, illegal_op, e.ill);
      for (int i = 0; i <= hold; i++) begin
        if (i > 0) @(negedge clk);
        chk({tag, ":result"}, result, e.res);
        chk({tag, ":busy"}, in_ready, 0);
        chk({tag, ":valid_hold"}, out_valid, 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    logic seen;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst:in_ready", in_ready, 1);
    chk("rst:out_valid", out_valid, 0);
    chk("rst:result", result, 0);
    chk("rst:illegal", illegal_op, 0);
    rst = 1'b0;

    run_op("mulhu_max", 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mul_3x5",   4'd0, 32'd3, 32'd5, 0);
    run_op("mul_6x7",   4'd0, 32'd6, 32'd7, 0);
    run_op("mul_neg",   4'd0, 32'hFFFF_FFF9, 32'd3, 0);
    run_op("mulh_neg",  4'd1, 32'hFFFF_FFFD, 32'd5, 0);
    run_op("mulh_mn",   4'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("mulhsu",    4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div_10_2",  4'd4, 32'd10, 32'd2, 0);
    run_op("div_ovf",   4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf",   4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_z",    4'd5, 32'd7, 32'd0, 0);
    run_op("remu_z",    4'd7, 32'd7, 32'd0, 0);
    run_op("rem_m7_2",  4'd6, 32'hFFFF_FFF9, 32'd2, 5);
    run_op("div_m7_2",  4'd4, 32'hFFFF_FFF9, 32'd2, 5);
    run_op("divu_big",  4'd5, 32'hF000_0001, 32'd16, 0);
    run_op("illegal",   4'd11, 32'd1, 32'd2, 0);

    for (int i = 0; i < 6; i++)
      run_op($sformatf("rand%0d", i), 4'($urandom_range(0, 7)), $urandom, $urandom, 0);

    // Reset in the middle of a multiply: no result may appear.
    @(negedge clk);
    in_valid = 1'b1; operation = MUL; A = 32'd9; B = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("midrst:in_ready", in_ready, 1);
    chk("midrst:out_valid", out_valid, 0);
    chk("midrst:result", result, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst:no_valid", seen, 0);
    run_op("mul_after_rst", 4'd0, 32'd3, 32'd5, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
